// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a registered one-hot grant and a matching binary select; owners may lock.
// Latency: 1 cycle from req to grant. No backpressure: req/lock are level inputs, decided every edge.
// Optional hold timeout with BUS_ARB_TIMEOUT_EN: force-releases a lock after HOLD_MAX kept cycles.
module bus_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int SEL_W    = 5,
    parameter int HOLD_MAX = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               bus_busy,
    output logic               hold_timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 32 || (1 << SEL_W) < NUM_REQ || HOLD_MAX < 2) begin : g_bad_param
        $error("bus_arbiter: illegal parameter combination");
    end

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [IDX_W-1:0]   found_idx;
    logic               found;
    logic               keep;
    logic               expire;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0]   sel_nxt;

    // Owner holds the bus only while its own req and lock are both high.
    assign keep = (state == OWNED) && (|(grant & req & lock));

    // Scan ptr, ptr+1, ... wrapping. After a grant ptr = owner+1, so the owner
    // is naturally the last candidate: a timed-out owner is re-granted only when alone.
    always_comb begin : p_scan
        logic [IDX_W:0] pos;
        found     = 1'b0;
        found_idx = '0;
        pos       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                pos = pos - (IDX_W + 1)'(NUM_REQ);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found     = 1'b1;
                found_idx = pos[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        grant_nxt = '0;
        sel_nxt   = '0;
        ptr_nxt   = ptr;
        if (keep && !expire) begin
            state_nxt = OWNED;
            grant_nxt = grant;
            sel_nxt   = sel;
        end else if (found) begin
            state_nxt            = OWNED;
            grant_nxt[found_idx] = 1'b1;
            sel_nxt              = SEL_W'(found_idx);
            ptr_nxt              = (found_idx == IDX_W'(NUM_REQ - 1)) ? '0 : found_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            bus_busy <= 1'b0;
            ptr      <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            bus_busy <= |grant_nxt;
            ptr      <= ptr_nxt;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] hold_cnt;

    // Counts locked-kept cycles; reaching HOLD_MAX means the next keep would exceed the bound.
    assign expire = keep && (hold_cnt == CNT_W'(HOLD_MAX));

    always_ff @(posedge clock) begin
        if (clear) begin
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
        end else begin
            hold_cnt     <= (keep && !expire) ? hold_cnt + 1'b1 : '0;
            hold_timeout <= expire;
        end
    end
`else
    assign expire       = 1'b0;
    assign hold_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus hand-written lock/timeout sequences.
module tb_bus_arbiter;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [7:0] req   = 8'h00;
    logic [7:0] lock  = 8'h00;
    logic [7:0] grant;
    logic [4:0] sel;
    logic       bus_busy;
    logic       hold_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    bus_arbiter #(.NUM_REQ(8), .SEL_W(5), .HOLD_MAX(4)) dut (
        .clock        (clock),
        .clear        (clear),
        .req          (req),
        .lock         (lock),
        .grant        (grant),
        .sel          (sel),
        .bus_busy     (bus_busy),
        .hold_timeout (hold_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       clr;
        logic [7:0] rq;
        logic [7:0] lk;
        logic [7:0] g;
        logic [4:0] s;
        logic       b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic [7:0] r, input logic [7:0] l,
                       input logic [7:0] g, input logic [4:0] s, input logic b);
        vec_t v;
        v.clr = c; v.rq = r; v.lk = l; v.g = g; v.s = s; v.b = b;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic c, input logic [7:0] r, input logic [7:0] l);
        clear = c;
        req   = r;
        lock  = l;
        tick();
    endtask

    task automatic check(input string nm, input int id, input logic [7:0] eg,
                         input logic [4:0] es, input logic eb, input logic et);
        n_cmp++;
        if (grant !== eg || sel !== es || bus_busy !== eb || hold_timeout !== et) begin
            n_bad++;
            $display("FAIL %s #%0d: got grant=%h sel=%0d busy=%b timeout=%b, want grant=%h sel=%0d busy=%b timeout=%b",
                     nm, id, grant, sel, bus_busy, hold_timeout, eg, es, eb, et);
        end
    endtask

    initial begin
        // Reset held with all requests pending.
        add(1, 8'hFF, 8'h00, 8'h00, 0, 0);
        add(1, 8'hFF, 8'h00, 8'h00, 0, 0);
        add(0, 8'hFF, 8'h00, 8'h01, 0, 1);
        // Full round-robin rotation.
        for (int i = 1; i < 8; i++) add(0, 8'hFF, 8'h00, 8'h01 << i, 5'(i), 1);
        add(0, 8'hFF, 8'h00, 8'h01, 0, 1);
        // Owner 6, then sparse requests wrapping past the end.
        add(0, 8'h40, 8'h00, 8'h40, 6, 1);
        add(0, 8'h05, 8'h00, 8'h01, 0, 1);
        add(0, 8'h05, 8'h00, 8'h04, 2, 1);
        add(0, 8'h05, 8'h00, 8'h01, 0, 1);
        add(0, 8'h00, 8'h00, 8'h00, 0, 0);
        // Ptr survives idle; then owner 3 locks for five cycles.
        add(0, 8'hFF, 8'h00, 8'h02, 1, 1);
        add(0, 8'hFF, 8'h00, 8'h04, 2, 1);
        for (int i = 0; i < 5; i++) add(0, 8'hFF, 8'h08, 8'h08, 3, 1);
        add(0, 8'hFF, 8'h00, 8'h10, 4, 1);
        // Lock from a non-owner, then lock without req, are ignored.
        add(0, 8'hFF, 8'h01, 8'h20, 5, 1);
        add(0, 8'h80, 8'h20, 8'h80, 7, 1);
        // Sole requester re-granted without lock.
        add(0, 8'h80, 8'h00, 8'h80, 7, 1);
        // Clear during a lock, then ptr restarts at 0.
        add(0, 8'h04, 8'h04, 8'h04, 2, 1);
        add(0, 8'h04, 8'h04, 8'h04, 2, 1);
        add(1, 8'hFF, 8'h04, 8'h00, 0, 0);
        add(0, 8'hFF, 8'h00, 8'h01, 0, 1);

        tick();
        check("reset_initial", 0, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].rq, vecs[i].lk);
            check("vec", i, vecs[i].g, vecs[i].s, vecs[i].b, 1'b0);
        end

        // ptr is now 1.
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'h22, 8'h02);
            check("to_hold", i, 8'h02, 1, 1, 0);
        end
        drive(0, 8'h22, 8'h02);
        check("to_release", 0, 8'h20, 5, 1, 1);
        drive(0, 8'h22, 8'h02);
        check("to_after", 0, 8'h02, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h02, 8'h02);
            check("to_solo_hold", i, 8'h02, 1, 1, 0);
        end
        drive(0, 8'h02, 8'h02);
        check("to_solo_regrant", 0, 8'h02, 1, 1, 1);
        drive(0, 8'h02, 8'h02);
        check("to_solo_rehold", 0, 8'h02, 1, 1, 0);
`else
        for (int i = 0; i < 20; i++) begin
            drive(0, 8'h22, 8'h02);
            check("long_lock", i, 8'h02, 1, 1, 0);
        end
        drive(0, 8'h22, 8'h00);
        check("long_lock_drop", 0, 8'h20, 5, 1, 0);
`endif
        drive(0, 8'h00, 8'h00);
        check("final_idle", 0, 8'h00, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
